// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: a one-entry line buffer in front of a simple
// request/ack memory bus, with a bounded wait that returns a NOP on timeout.
module inst_fetch_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        stall_req_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;
  logic        hit;
  logic        unused_addr_lsb;

  // Byte offset within the word never affects which line is fetched.
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit         = valid_q && (tag_q == cpu_addr_i[31:2]);
  assign cpu_inst_o  = (cpu_ce_i && hit) ? data_q : 32'h0;
  assign stall_req_o = cpu_ce_i && !hit;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = {bus_addr_q, 2'b00};
  assign err_o       = err_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    err_d      = 1'b0;
    drop_d     = drop_q;

    if (flush_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_ce_i && !hit && !flush_i) begin
          state_d    = BUSY;
          bus_req_d  = 1'b1;
          bus_addr_d = cpu_addr_i[31:2];
          cnt_d      = 8'd0;
          drop_d     = 1'b0;
        end
      end
      BUSY: begin
        // A flush while waiting lets the bus transfer finish but discards it.
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!drop_q && !flush_i) begin
            data_d  = bus_rdata_i;
            tag_d   = bus_addr_q;
            valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          if (!drop_q && !flush_i) begin
            data_d  = 32'h0;
            tag_d   = bus_addr_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge (TIMEOUT=4) with a queue-based scoreboard
// for bus addresses and returned instructions.
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_inst_o;
  logic        stall_req_o;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  int n_chk  = 0;
  int n_fail = 0;
  int dead_seen = 0;

  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];

  int nreq, nerr, nst;

  inst_fetch_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
    .cpu_inst_o(cpu_inst_o), .stall_req_o(stall_req_o),
    .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cpu_inst_o === 32'hDEADBEEF) dead_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_or_x(ref logic [31:0] q[$]);
    if (q.size() == 0) return 32'hxxxxxxxx;
    return q.pop_front();
  endfunction

  // Steps from the current negedge through one request; returns at the negedge
  // of the first cycle after bus_req_o has fallen.
  task automatic run_req(input int ack_at, input logic [31:0] rd, input int flush_at,
                         output int req_n, output int err_n, output int st_n);
    bit seen = 0;
    bit done = 0;
    logic [31:0] first_addr = '0;
    int unstable = 0;
    req_n = 0; err_n = 0; st_n = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0; flush_i = 1'b0;
      @(negedge clk);
      if (err_o) err_n++;
      if (bus_req_o) begin
        if (!seen) begin
          first_addr = bus_addr_o;
          check("bus_addr", bus_addr_o, pop_or_x(addr_q));
        end else if (bus_addr_o !== first_addr) unstable++;
        seen = 1;
        req_n++;
        if (stall_req_o) st_n++;
        if (req_n == flush_at) flush_i = 1'b1;
        if (req_n == ack_at) begin bus_ack_i = 1'b1; bus_rdata_i = rd; end
      end else if (seen) done = 1;
    end
    check("req_done", {31'h0, done}, 32'h1);
    check("addr_stable", unstable, 0);
  endtask

  initial begin
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = 32'h0; flush_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", bus_req_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_req_o, 0);
    check("rst_inst", cpu_inst_o, 0);
    @(posedge clk); #1; rst = 1'b1;

    // First fetch after reset misses; ack in 3rd BUSY cycle
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0104;
    addr_q.push_back(32'h0000_0104); exp_q.push_back(32'h3401_1100);
    @(negedge clk);
    check("first_miss_stall", stall_req_o, 1);
    check("first_miss_inst", cpu_inst_o, 0);
    check("first_miss_noreq", bus_req_o, 0);
    run_req(3, 32'h3401_1100, 0, nreq, nerr, nst);
    check("fill_req_cycles", nreq, 3);
    check("fill_stall_cycles", nst, 3);
    check("fill_err", nerr, 0);
    check("fill_stall_after", stall_req_o, 0);
    check("fill_inst", cpu_inst_o, pop_or_x(exp_q));

    // Same word, different byte offset: hit with no bus traffic
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0106;
    @(negedge clk);
    check("hit_stall", stall_req_o, 0);
    check("hit_inst", cpu_inst_o, 32'h3401_1100);
    @(posedge clk); #1;
    @(negedge clk);
    check("hit_noreq", bus_req_o, 0);

    // Timeout: no ack, four request cycles, one err pulse, NOP returned
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0200;
    addr_q.push_back(32'h0000_0200); exp_q.push_back(32'h0);
    @(negedge clk);
    check("to_miss_stall", stall_req_o, 1);
    run_req(0, 32'h0, 0, nreq, nerr, nst);
    check("to_req_cycles", nreq, 4);
    check("to_err_pulses", nerr, 1);
    check("to_stall_after", stall_req_o, 0);
    check("to_inst", cpu_inst_o, pop_or_x(exp_q));
    @(posedge clk); #1;
    @(negedge clk);
    check("to_err_single", err_o, 0);

    // Ack coinciding with the timeout cycle wins
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0300;
    addr_q.push_back(32'h0000_0300); exp_q.push_back(32'hA5A5_0001);
    @(negedge clk);
    run_req(4, 32'hA5A5_0001, 0, nreq, nerr, nst);
    check("tie_req_cycles", nreq, 4);
    check("tie_err", nerr, 0);
    check("tie_inst", cpu_inst_o, pop_or_x(exp_q));
    @(posedge clk); #1;
    @(negedge clk);
    check("tie_err_next", err_o, 0);

    // Minimum latency: ack in the first BUSY cycle, hit two cycles after miss
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0400;
    addr_q.push_back(32'h0000_0400); exp_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    run_req(1, 32'h0BAD_F00D, 0, nreq, nerr, nst);
    check("lat_req_cycles", nreq, 1);
    check("lat_stall", stall_req_o, 0);
    check("lat_inst", cpu_inst_o, pop_or_x(exp_q));

    // Flush in 2nd BUSY cycle: response discarded, request reissued
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0500;
    addr_q.push_back(32'h0000_0500);
    @(negedge clk);
    run_req(3, 32'hDEAD_BEEF, 2, nreq, nerr, nst);
    check("flush_err", nerr, 0);
    check("flush_stall", stall_req_o, 1);
    check("flush_inst", cpu_inst_o, 0);
    addr_q.push_back(32'h0000_0500); exp_q.push_back(32'h1234_5678);
    run_req(1, 32'h1234_5678, 0, nreq, nerr, nst);
    check("refetch_req_cycles", nreq, 1);
    check("refetch_inst", cpu_inst_o, pop_or_x(exp_q));

    // Flush in IDLE suppresses a new request that cycle
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0600; flush_i = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", stall_req_o, 1);
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    check("idle_flush_noreq", bus_req_o, 0);
    addr_q.push_back(32'h0000_0600); exp_q.push_back(32'h600D_0600);
    run_req(2, 32'h600D_0600, 0, nreq, nerr, nst);
    check("after_flush_inst", cpu_inst_o, pop_or_x(exp_q));
    check("dead_never_seen", dead_seen, 0);

    // Reset mid-BUSY abandons the request; late ack ignored
    @(posedge clk); #1; cpu_addr_i = 32'h0000_0700;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_busy_req", bus_req_o, 1);
    rst = 1'b0; cpu_ce_i = 1'b0;
    #1;
    check("rst_async_req", bus_req_o, 0);
    check("rst_async_addr", bus_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_noreq", bus_req_o, 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0; cpu_ce_i = 1'b1;
    @(negedge clk);
    check("post_rst_stall", stall_req_o, 1);
    check("post_rst_inst", cpu_inst_o, 0);
    check("post_rst_err", err_o, 0);

    @(posedge clk); #1; cpu_ce_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum bus-wait cycles per fetch (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port cpu_ce_i  input  1  instruction-port enable from the core.
REQ-005 The block SHALL have port cpu_addr_i  input  32  fetch address from the core.
REQ-006 The block SHALL have port cpu_inst_o  output  32  instruction returned to the core.
REQ-007 The block SHALL have port stall_req_o  output  1  fetch not yet satisfied; the front end holds the PC.
REQ-008 The block SHALL have port flush_i  input  1  invalidate the buffered line and drop any outstanding response.
REQ-009 The block SHALL have port bus_req_o  output  1  memory read request; registered.
REQ-010 The block SHALL have port bus_addr_o  output  32  word-aligned memory read address; registered.
REQ-011 The block SHALL have port bus_ack_i  input  1  one-cycle read-data-valid strobe from memory.
REQ-012 The block SHALL have port bus_rdata_i  input  32  read data, valid when bus_ack_i=1.
REQ-013 The block SHALL have port err_o  output  1  one-cycle pulse on fetch timeout.

Function
REQ-014 The block SHALL hold a one-entry buffer with fields valid, tag[29:0] and data[31:0]; hit = valid && tag==cpu_addr_i[31:2], and cpu_addr_i[1:0] SHALL be ignored.
REQ-015 cpu_inst_o SHALL be combinational: the buffer data when cpu_ce_i && hit, else 32'h0.
REQ-016 stall_req_o SHALL be combinational, equal to cpu_ce_i && !hit, in every state.
REQ-017 The FSM SHALL have states IDLE and BUSY.
REQ-018 IDLE->BUSY: on the edge where cpu_ce_i && !hit && !flush_i, the block SHALL register bus_req_o=1 and bus_addr_o={cpu_addr_i[31:2],2'b00}, and clear the wait counter to 0.
REQ-019 In BUSY, bus_req_o and bus_addr_o SHALL hold stable until the request terminates; cpu_addr_i changes SHALL NOT alter the in-flight address.
REQ-020 BUSY with bus_ack_i=1: the block SHALL load data=bus_rdata_i, tag=bus_addr_o[31:2] and valid=1 (unless the request is dropped per REQ-024), deassert bus_req_o, and return to IDLE at that edge.
REQ-021 BUSY without ack: the counter SHALL increment each cycle. When counter==TIMEOUT-1, the block SHALL abort at that edge: data=32'h0 (NOP), tag=bus_addr_o[31:2], valid=1, err_o=1 for exactly the next cycle, bus_req_o=0, and the FSM returns to IDLE.
REQ-022 If bus_ack_i and the timeout condition coincide, ack SHALL win: no err_o, and bus data is loaded.
REQ-023 bus_ack_i in IDLE SHALL be ignored.
REQ-024 flush_i=1 SHALL clear valid at the next edge. If BUSY, the request SHALL continue until ack or timeout, but its response SHALL be discarded (valid stays 0, err_o still pulses on timeout).
REQ-025 flush_i in IDLE SHALL suppress a new request in that cycle.
REQ-026 Minimum miss latency: with the miss presented in cycle N and ack in cycle N+1, the hit SHALL occur and stall_req_o SHALL fall in cycle N+2.
REQ-027 After completion, a still-missing address (changed mid-request) SHALL trigger a new request from IDLE on the following edge.

Reset
REQ-028 While rst=0, the block SHALL immediately force state=IDLE, valid=0, tag=0, data=0, counter=0, bus_req_o=0, bus_addr_o=0 and err_o=0, independent of clk.
REQ-029 Reset asserted mid-BUSY SHALL abandon the request; a later bus_ack_i SHALL be ignored.
REQ-030 Following reset release, the first cpu_ce_i=1 cycle SHALL miss.

Verification
REQ-031 Reset, then cpu_ce_i=1 and addr=0x00000104; ack after 3 BUSY cycles with rdata=0x34011100 -> bus_addr_o=0x00000104; stall_req_o=1 until ack+1, then cpu_inst_o=0x34011100.
REQ-032 Repeat addr 0x00000106 after the fill -> immediate hit, no bus_req_o, cpu_inst_o=0x34011100.
REQ-033 TIMEOUT=4, no ack -> bus_req_o high for exactly 4 cycles, one err_o pulse, cpu_inst_o=0x00000000, stall_req_o=0.
REQ-034 TIMEOUT=4, ack in the 4th BUSY cycle -> no err_o, data loaded.
REQ-035 flush_i in the 2nd BUSY cycle, ack with 0xDEADBEEF -> valid=0, new request issued, 0xDEADBEEF never appears on cpu_inst_o.
REQ-036 Drive rst=0 mid-BUSY, then ack after release -> bus_req_o=0 immediately, buffer stays invalid, ack ignored.
